// File: rtl/itch_pkg.sv
// Shared ITCH definitions: message type codes, dispatcher FSM encoding and
// parser select indices.
package itch_pkg;

  localparam logic [7:0] ITCH_ADD = 8'h41;
  localparam logic [7:0] ITCH_DEL = 8'h44;
  localparam logic [7:0] ITCH_EXE = 8'h45;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_DROP   = 2'd2;
  localparam state_t ST_CLEAR  = 2'd3;

  localparam int unsigned SEL_ADD = 0;
  localparam int unsigned SEL_DEL = 1;
  localparam int unsigned SEL_EXE = 2;

  // Smallest message length the dispatcher sequencing can handle.
  localparam int unsigned MIN_LEN = 2;

endpackage

// File: rtl/itch_msg_dispatcher_if.sv
// Framed beat stream from the framer into the message dispatcher.
interface itch_msg_dispatcher_if;

  logic [63:0] dataIn;
  logic        dataValid;
  logic        msgStart;
  logic        inReady;

  modport master (
    output dataIn,
    output dataValid,
    output msgStart,
    input  inReady
  );

  modport slave (
    input  dataIn,
    input  dataValid,
    input  msgStart,
    output inReady
  );

endinterface

// File: rtl/itch_type_decode.sv
// Combinational ITCH type byte decode into {valid, one-hot parser select, length}.
module itch_type_decode
  import itch_pkg::*;
#(
  parameter int unsigned LEN_ADD = 5,
  parameter int unsigned LEN_DEL = 3,
  parameter int unsigned LEN_EXE = 4
) (
  input  logic [7:0] typeByte,
  output logic       valid,
  output logic [2:0] sel,
  output logic [3:0] len
);

  always_comb begin
    valid = 1'b0;
    sel   = 3'b000;
    len   = 4'd0;
    case (typeByte)
      ITCH_ADD: begin
        valid        = 1'b1;
        sel[SEL_ADD] = 1'b1;
        len          = 4'(LEN_ADD);
      end
      ITCH_DEL: begin
        valid        = 1'b1;
        sel[SEL_DEL] = 1'b1;
        len          = 4'(LEN_DEL);
      end
      ITCH_EXE: begin
        valid        = 1'b1;
        sel[SEL_EXE] = 1'b1;
        len          = 4'(LEN_EXE);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/itch_msg_dispatcher.sv
// Sequences framed ITCH beats to the per-type field parsers, then pulses msgDone
// and clears the selected parser for one cycle while stalling upstream.
module itch_msg_dispatcher
  import itch_pkg::*;
#(
  parameter int unsigned FIRST_BEAT = 8,
  parameter int unsigned LEN_ADD    = 5,
  parameter int unsigned LEN_DEL    = 3,
  parameter int unsigned LEN_EXE    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  itch_msg_dispatcher_if.slave  up,
  output logic [3:0]            counter,
  output logic                  startAddOrder,
  output logic                  startOrderDelete,
  output logic                  startOrderExecuted,
  output logic [2:0]            parserClr,
  output logic                  msgDone,
  output logic [7:0]            msgType,
  output logic                  errTruncated,
  output logic                  errOrphan,
  output logic                  errUnknown,
  output logic [15:0]           cntAdd,
  output logic [15:0]           cntDel,
  output logic [15:0]           cntExe,
  output logic [15:0]           cntDrop
);

  if (LEN_ADD < MIN_LEN || LEN_DEL < MIN_LEN || LEN_EXE < MIN_LEN) begin : gen_bad_len
    $error("itch_msg_dispatcher: message lengths must be at least 2");
  end
  if (FIRST_BEAT < 1) begin : gen_bad_first
    $error("itch_msg_dispatcher: FIRST_BEAT must be at least 1");
  end

  state_t      stateQ, stateD;
  logic [2:0]  selQ, selD;
  logic [3:0]  beatIdxQ, beatIdxD;
  logic [3:0]  lenQ, lenD;
  logic [7:0]  typeQ, typeD;

  logic        inReadyQ;
  logic [2:0]  parserClrQ;
  logic        msgDoneQ;
  logic [7:0]  msgTypeQ;
  logic        errTruncQ, errOrphQ, errUnkQ;
  logic [15:0] cntAddQ, cntDelQ, cntExeQ, cntDropQ;

  logic        decValid;
  logic [2:0]  decSel;
  logic [3:0]  decLen;

  logic        accept;
  logic        present;
  logic [2:0]  presentSel;
  logic [3:0]  presentIdx;
  logic        truncate, orphan, unknown;

  itch_type_decode #(
    .LEN_ADD (LEN_ADD),
    .LEN_DEL (LEN_DEL),
    .LEN_EXE (LEN_EXE)
  ) u_decode (
    .typeByte (up.dataIn[7:0]),
    .valid    (decValid),
    .sel      (decSel),
    .len      (decLen)
  );

  assign accept = up.dataValid && inReadyQ;

  always_comb begin
    stateD     = stateQ;
    selD       = selQ;
    beatIdxD   = beatIdxQ;
    lenD       = lenQ;
    typeD      = typeQ;
    present    = 1'b0;
    presentSel = 3'b000;
    presentIdx = 4'd0;
    truncate   = 1'b0;
    orphan     = 1'b0;
    unknown    = 1'b0;
    case (stateQ)
      ST_IDLE, ST_DROP: begin
        if (accept && up.msgStart) begin
          if (decValid) begin
            present    = 1'b1;
            presentSel = decSel;
            selD       = decSel;
            beatIdxD   = 4'd1;
            lenD       = decLen;
            typeD      = up.dataIn[7:0];
            stateD     = ST_ACTIVE;
          end else begin
            unknown = 1'b1;
            stateD  = ST_DROP;
          end
        end else if (accept && stateQ == ST_IDLE) begin
          orphan = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (accept && up.msgStart) begin
          // New message while one is open: discard the beat, upstream resends.
          truncate = 1'b1;
          stateD   = ST_IDLE;
        end else if (accept) begin
          present    = 1'b1;
          presentSel = selQ;
          presentIdx = beatIdxQ;
          beatIdxD   = beatIdxQ + 4'd1;
          if (beatIdxQ == lenQ - 4'd1) begin
            stateD = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: stateD = ST_IDLE;
      default:  stateD = ST_IDLE;
    endcase
  end

  assign counter            = present ? 4'(FIRST_BEAT) + presentIdx : 4'd0;
  assign startAddOrder      = present && presentSel[SEL_ADD];
  assign startOrderDelete   = present && presentSel[SEL_DEL];
  assign startOrderExecuted = present && presentSel[SEL_EXE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= ST_IDLE;
      selQ     <= 3'b000;
      beatIdxQ <= 4'd0;
      lenQ     <= 4'd0;
      typeQ    <= 8'h00;
    end else begin
      stateQ   <= stateD;
      selQ     <= selD;
      beatIdxQ <= beatIdxD;
      lenQ     <= lenD;
      typeQ    <= typeD;
    end
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inReadyQ   <= 1'b1;
      parserClrQ <= 3'b000;
      msgDoneQ   <= 1'b0;
      msgTypeQ   <= 8'h00;
      errTruncQ  <= 1'b0;
      errOrphQ   <= 1'b0;
      errUnkQ    <= 1'b0;
    end else begin
      inReadyQ  <= (stateD != ST_CLEAR);
      msgDoneQ  <= (stateD == ST_CLEAR);
      errTruncQ <= truncate;
      errOrphQ  <= orphan;
      errUnkQ   <= unknown;
      if (stateD == ST_CLEAR) begin
        parserClrQ <= selD;
        msgTypeQ   <= typeQ;
      end else if (truncate) begin
        parserClrQ <= selQ;
      end else begin
        parserClrQ <= 3'b000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntAddQ  <= 16'h0000;
      cntDelQ  <= 16'h0000;
      cntExeQ  <= 16'h0000;
      cntDropQ <= 16'h0000;
    end else begin
      if (stateQ == ST_CLEAR) begin
        if (selQ[SEL_ADD]) cntAddQ <= cntAddQ + 16'd1;
        if (selQ[SEL_DEL]) cntDelQ <= cntDelQ + 16'd1;
        if (selQ[SEL_EXE]) cntExeQ <= cntExeQ + 16'd1;
      end
      if ((truncate || unknown) && cntDropQ != 16'hFFFF) begin
        cntDropQ <= cntDropQ + 16'd1;
      end
    end
  end

  assign up.inReady   = inReadyQ;
  assign parserClr    = parserClrQ;
  assign msgDone      = msgDoneQ;
  assign msgType      = msgTypeQ;
  assign errTruncated = errTruncQ;
  assign errOrphan    = errOrphQ;
  assign errUnknown   = errUnkQ;
  assign cntAdd       = cntAddQ;
  assign cntDel       = cntDelQ;
  assign cntExe       = cntExeQ;
  assign cntDrop      = cntDropQ;

endmodule

// File: tb/tb_itch_msg_dispatcher.sv
// Bench for itch_msg_dispatcher: directed scenarios then random message traffic,
// checked every cycle against a message-level reference model.
module tb_itch_msg_dispatcher;

  localparam int FB = 8;
  localparam int LA = 5;
  localparam int LD = 3;
  localparam int LE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  itch_msg_dispatcher_if bus ();

  logic [3:0]  counter;
  logic        sa, sd, se;
  logic [2:0]  parserClr;
  logic        msgDone;
  logic [7:0]  msgType;
  logic        errTruncated, errOrphan, errUnknown;
  logic [15:0] cntAdd, cntDel, cntExe, cntDrop;

  itch_msg_dispatcher #(
    .FIRST_BEAT (FB),
    .LEN_ADD    (LA),
    .LEN_DEL    (LD),
    .LEN_EXE    (LE)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .up                 (bus),
    .counter            (counter),
    .startAddOrder      (sa),
    .startOrderDelete   (sd),
    .startOrderExecuted (se),
    .parserClr          (parserClr),
    .msgDone            (msgDone),
    .msgType            (msgType),
    .errTruncated       (errTruncated),
    .errOrphan          (errOrphan),
    .errUnknown         (errUnknown),
    .cntAdd             (cntAdd),
    .cntDel             (cntDel),
    .cntExe             (cntExe),
    .cntDrop            (cntDrop)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the open message (length, beats seen), drop mode and
  // whether the current cycle is the post-message clear cycle.
  int          mLen, mK;
  logic [7:0]  mType;
  bit          mDrop, mClear;
  bit          eDone, eTrunc, eOrph, eUnk;
  logic [2:0]  eClr;
  logic [7:0]  eType;
  logic [15:0] eAdd, eDel, eExe, eDrop;

  function automatic int type_len(input logic [7:0] t);
    case (t)
      8'h41:   return LA;
      8'h44:   return LD;
      8'h45:   return LE;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] type_sel(input logic [7:0] t);
    case (t)
      8'h41:   return 3'b001;
      8'h44:   return 3'b010;
      8'h45:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    mLen = 0; mK = 0; mType = 8'h00; mDrop = 0; mClear = 0;
    eDone = 0; eTrunc = 0; eOrph = 0; eUnk = 0; eClr = 3'b000; eType = 8'h00;
    eAdd = 16'h0; eDel = 16'h0; eExe = 16'h0; eDrop = 16'h0;
  endtask

  task automatic bump_drop();
    if (eDrop != 16'hFFFF) eDrop = eDrop + 16'd1;
  endtask

  // One clock: drive inputs after the falling edge, check, advance the model.
  task automatic step(input logic v, input logic s, input logic [63:0] d, output bit acc);
    bit         pres;
    int         kPres;
    logic [2:0] psel;
    logic [7:0] t;
    bus.dataValid = v;
    bus.msgStart  = s;
    bus.dataIn    = d;
    #1;
    t     = d[7:0];
    acc   = v && !mClear;
    pres  = 0;
    kPres = 0;
    psel  = 3'b000;
    if (acc) begin
      if (mLen == 0) begin
        if (s && type_len(t) != 0) begin
          pres = 1; psel = type_sel(t);
        end
      end else if (!s) begin
        pres = 1; kPres = mK; psel = type_sel(mType);
      end
    end
    check("inReady", 32'(bus.inReady), 32'(!mClear));
    check("counter", 32'(counter), pres ? 32'(FB + kPres) : 32'd0);
    check("starts", 32'({se, sd, sa}), 32'(psel));
    check("parserClr", 32'(parserClr), 32'(eClr));
    check("msgDone", 32'(msgDone), 32'(eDone));
    if (eDone) check("msgType", 32'(msgType), 32'(eType));
    check("errs", 32'({errTruncated, errOrphan, errUnknown}), 32'({eTrunc, eOrph, eUnk}));
    check("cntAdd", 32'(cntAdd), 32'(eAdd));
    check("cntDel", 32'(cntDel), 32'(eDel));
    check("cntExe", 32'(cntExe), 32'(eExe));
    check("cntDrop", 32'(cntDrop), 32'(eDrop));

    eDone = 0; eTrunc = 0; eOrph = 0; eUnk = 0; eClr = 3'b000;
    if (mClear) begin
      case (mType)
        8'h41:   eAdd = eAdd + 16'd1;
        8'h44:   eDel = eDel + 16'd1;
        default: eExe = eExe + 16'd1;
      endcase
      mClear = 0;
      mLen   = 0;
    end else if (acc) begin
      if (mLen == 0) begin
        if (s) begin
          if (type_len(t) != 0) begin
            mLen = type_len(t); mK = 1; mType = t; mDrop = 0;
          end else begin
            eUnk = 1; bump_drop(); mDrop = 1;
          end
        end else if (!mDrop) begin
          eOrph = 1;
        end
      end else if (s) begin
        eTrunc = 1; eClr = type_sel(mType); bump_drop(); mLen = 0; mDrop = 0;
      end else begin
        mK++;
        if (mK == mLen) begin
          eDone = 1; eClr = type_sel(mType); eType = mType; mClear = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send_beat(input logic s, input logic [63:0] d);
    bit acc;
    acc = 0;
    for (int i = 0; i < 4 && !acc; i++) step(1'b1, s, d, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, {$urandom, $urandom}, acc);
  endtask

  function automatic logic [63:0] beat_of(input logic [7:0] t);
    logic [63:0] d;
    d      = {$urandom, $urandom};
    d[7:0] = t;
    return d;
  endfunction

  // Type beat plus nb-1 continuation beats, with optional random gaps.
  task automatic send_msg(input logic [7:0] t, input int nb, input bit gaps);
    send_beat(1'b1, beat_of(t));
    for (int i = 1; i < nb; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      send_beat(1'b0, {$urandom, $urandom});
    end
  endtask

  task automatic do_reset();
    bus.dataValid = 1'b0;
    bus.msgStart  = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_inReady", 32'(bus.inReady), 32'd1);
    check("rst_counter", 32'(counter), 32'd0);
    check("rst_starts", 32'({se, sd, sa}), 32'd0);
    check("rst_parserClr", 32'(parserClr), 32'd0);
    check("rst_msgDone", 32'(msgDone), 32'd0);
    check("rst_msgType", 32'(msgType), 32'd0);
    check("rst_errs", 32'({errTruncated, errOrphan, errUnknown}), 32'd0);
    check("rst_counts", {cntAdd, cntDel} | {cntExe, cntDrop}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    bit acc;
    bus.dataValid = 1'b0;
    bus.msgStart  = 1'b0;
    bus.dataIn    = 64'h0;
    model_reset();
    @(negedge clk);
    do_reset();
    idle(2);

    // Gapless delete message.
    send_msg(8'h44, LD, 1'b0);
    idle(2);
    check("dir_cntDel", 32'(cntDel), 32'd1);

    // Add message with two idle cycles after beat 1.
    send_beat(1'b1, beat_of(8'h41));
    send_beat(1'b0, {$urandom, $urandom});
    idle(2);
    for (int i = 2; i < LA; i++) send_beat(1'b0, {$urandom, $urandom});
    idle(2);
    check("dir_cntAdd", 32'(cntAdd), 32'd1);

    // Truncated executed message, then a complete one.
    send_beat(1'b1, beat_of(8'h45));
    send_beat(1'b0, {$urandom, $urandom});
    send_beat(1'b1, beat_of(8'h45));
    idle(1);
    check("dir_cntDrop_trunc", 32'(cntDrop), 32'd1);
    send_msg(8'h45, LE, 1'b0);
    idle(2);
    check("dir_cntExe", 32'(cntExe), 32'd1);

    // Reset in the middle of an add message.
    send_beat(1'b1, beat_of(8'h41));
    send_beat(1'b0, {$urandom, $urandom});
    do_reset();

    // Unknown type with trailing beats, then a delete message.
    send_msg(8'h58, 4, 1'b0);
    idle(1);
    check("dir_cntDrop_unk", 32'(cntDrop), 32'd1);
    send_msg(8'h44, LD, 1'b0);
    idle(2);
    check("dir_cntDel_after", 32'(cntDel), 32'd1);

    // Back-to-back delete then add; add type beat is held over the clear cycle.
    send_msg(8'h44, LD, 1'b0);
    send_msg(8'h41, LA, 1'b0);
    idle(2);
    check("dir_b2b_cntAdd", 32'(cntAdd), 32'd1);
    check("dir_b2b_cntDel", 32'(cntDel), 32'd2);

    // Random traffic.
    for (int m = 0; m < 400; m++) begin
      int kind;
      kind = $urandom_range(0, 99);
      if (kind < 75) begin
        logic [7:0] t;
        int nb;
        case ($urandom_range(0, 2))
          0:       t = 8'h41;
          1:       t = 8'h44;
          default: t = 8'h45;
        endcase
        nb = type_len(t);
        if ($urandom_range(0, 9) == 0) nb = $urandom_range(1, nb - 1);
        send_msg(t, nb, $urandom_range(0, 1) == 1);
      end else if (kind < 87) begin
        logic [7:0] t;
        t = 8'($urandom_range(0, 255));
        if (type_len(t) != 0) t = 8'h00;
        send_msg(t, $urandom_range(1, 4), 1'b1);
      end else begin
        send_beat(1'b0, {$urandom, $urandom});
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    step(1'b0, 1'b0, 64'h0, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
